// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor: resolves CHUNK bits per clock through a
// ripple chain of full-add cells, LSB chunk first, with the inter-chunk carry held in a register.
module chunked_add_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_add_sub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [KW-1:0]    k;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic [CHUNK:0]   c_chain;
    logic [WIDTH-1:0] work_next;
    logic             last_chunk;

    // Full-add chain over the current chunk; c_chain[CHUNK-1] is the carry into the chunk's top bit,
    // which on the last chunk is the carry into the MSB needed for overflow.
    always_comb begin
        base       = 32'(k) * 32'(CHUNK);
        a_slice    = a_reg[base +: CHUNK];
        b_slice    = b_reg[base +: CHUNK];
        s_slice    = '0;
        c_chain    = '0;
        c_chain[0] = carry;
        for (int i = 0; i < CHUNK; i++) begin
            s_slice[i]   = a_slice[i] ^ b_slice[i] ^ c_chain[i];
            c_chain[i+1] = (a_slice[i] & b_slice[i]) | (c_chain[i] & (a_slice[i] ^ b_slice[i]));
        end
        work_next              = work;
        work_next[base +: CHUNK] = s_slice;
        last_chunk             = (k == KW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            k     <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            work  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1, so cin has no effect in sub mode.
                        a_reg <= A;
                        b_reg <= sub ? ~B : B;
                        carry <= sub ? 1'b1 : cin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= c_chain[CHUNK];
                    if (last_chunk) begin
                        sum   <= work_next;
                        cout  <= c_chain[CHUNK];
                        ovf   <= c_chain[CHUNK-1] ^ c_chain[CHUNK];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: a 1-bit instance plus WIDTH=8 instances with CHUNK 1/2/4/8,
// directed vectors with hand-computed results checked by a queue-based monitor.
module tb_chunked_add_sub;

    // Handshake: an operation is issued by holding start high across a rising edge while the
    // instance is in IDLE or DONE; its result is valid in the single cycle where done is high.

    logic             clk;
    logic             rst;
    logic [4:0]       start_v;
    logic [7:0]       a_in;
    logic [7:0]       b_in;
    logic             cin_in;
    logic             sub_in;
    logic [4:0]       busy_v;
    logic [4:0]       done_v;
    logic [4:0]       cout_v;
    logic [4:0]       ovf_v;
    logic [4:0][7:0]  sum_v;
    logic [4:0][1:0]  st_v;
    logic [0:0]       sum0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Instance 0 is WIDTH=1/CHUNK=1; instances 1..4 are WIDTH=8 with CHUNK 1,2,4,8.
    int nch [5] = '{1, 8, 4, 2, 1};

    logic [9:0] exp_q [5][$];
    int         iss_q [5][$];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       s;
        logic [7:0] r;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vt [14] = '{
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0},
        '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
        '{8'h09, 8'h09, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
        '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1},
        '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0},
        '{8'hC8, 8'h32, 1'b0, 1'b1, 8'h96, 1'b1, 1'b0},
        '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0},
        '{8'hFF, 8'h7F, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0}
    };

    // Full-adder truth table indexed by {a,b,cin}; ovf of a 1-bit add is cin ^ cout.
    logic [7:0] sum_tt  = 8'b1001_0110;
    logic [7:0] cout_tt = 8'b1110_1000;
    logic [7:0] ovf_tt  = 8'b0100_0010;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    chunked_add_sub #(.WIDTH(1), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in[0]), .B(b_in[0]),
        .cin(cin_in), .sub(sub_in), .busy(busy_v[0]), .done(done_v[0]), .sum(sum0),
        .cout(cout_v[0]), .ovf(ovf_v[0]), .dbg_state(st_v[0])
    );
    assign sum_v[0] = {7'b0, sum0};

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        chunked_add_sub #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g+1]), .A(a_in), .B(b_in),
            .cin(cin_in), .sub(sub_in), .busy(busy_v[g+1]), .done(done_v[g+1]), .sum(sum_v[g+1]),
            .cout(cout_v[g+1]), .ovf(ovf_v[g+1]), .dbg_state(st_v[g+1])
        );
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h (t=%0t)", name, inst, got, want, $time);
        end
    endtask

    task automatic monitor_step();
        logic [9:0] e;
        int         iss;
        for (int m = 0; m < 5; m++) begin
            if (done_v[m]) begin
                if (exp_q[m].size() == 0) begin
                    check("unexpected_done", m, 32'(done_v[m]), 32'd0);
                end else begin
                    e   = exp_q[m].pop_front();
                    iss = iss_q[m].pop_front();
                    check("result", m, 32'({sum_v[m], cout_v[m], ovf_v[m]}), 32'(e));
                    check("latency", m, 32'(cyc - iss - 1), 32'(nch[m]));
                    check("busy_at_done", m, 32'(busy_v[m]), 32'd0);
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_done(input int idx);
        int t;
        t = 0;
        while (!done_v[idx] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("done_wait", idx, 32'(done_v[idx]), 32'd1);
    endtask

    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input logic [9:0] e);
        a_in         = a;
        b_in         = b;
        cin_in       = c;
        sub_in       = s;
        start_v[idx] = 1'b1;
        exp_q[idx].push_back(e);
        iss_q[idx].push_back(cyc);
        @(negedge clk);
        start_v[idx] = 1'b0;
        wait_done(idx);
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst     = 1'b1;
        start_v = '0;
        a_in    = '0;
        b_in    = '0;
        cin_in  = 1'b0;
        sub_in  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(negedge clk);
        for (int m = 0; m < 5; m++) begin
            check("rst_busy", m, 32'(busy_v[m]), 32'd0);
            check("rst_done", m, 32'(done_v[m]), 32'd0);
            check("rst_sum", m, 32'(sum_v[m]), 32'd0);
            check("rst_cout_ovf", m, 32'({cout_v[m], ovf_v[m]}), 32'd0);
            check("rst_state", m, 32'(st_v[m]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // start held for 10 cycles with operands changing every cycle: only the values present at
        // the two acceptance edges (cycle 0 and cycle 5) may reach the result.
        for (int i = 0; i < 10; i++) begin
            if (i >= 1 && i <= 4) begin
                check("run_sum_hold0", 2, 32'(sum_v[2]), 32'h00);
                check("run_busy", 2, 32'(busy_v[2]), 32'd1);
            end
            if (i >= 6 && i <= 9) check("run_sum_hold31", 2, 32'(sum_v[2]), 32'h31);
            a_in       = 8'h10 + 8'(i);
            b_in       = 8'h20;
            cin_in     = 1'b1;
            sub_in     = 1'b0;
            start_v[2] = 1'b1;
            if (i == 0) begin
                exp_q[2].push_back({8'h31, 1'b0, 1'b0});
                iss_q[2].push_back(cyc);
            end
            if (i == 5) begin
                exp_q[2].push_back({8'h36, 1'b0, 1'b0});
                iss_q[2].push_back(cyc);
            end
            @(negedge clk);
        end
        start_v[2] = 1'b0;
        wait_done(2);
        @(negedge clk);

        // Abort FF+01 in its second RUN cycle; no done may follow.
        a_in       = 8'hFF;
        b_in       = 8'h01;
        cin_in     = 1'b0;
        sub_in     = 1'b0;
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 2, 32'(busy_v[2]), 32'd0);
        check("abort_done", 2, 32'(done_v[2]), 32'd0);
        check("abort_sum", 2, 32'(sum_v[2]), 32'h00);
        check("abort_cout_ovf", 2, 32'({cout_v[2], ovf_v[2]}), 32'd0);
        check("abort_state", 2, 32'(st_v[2]), 32'd0);
        repeat (6) @(negedge clk);
        run_op(2, 8'h03, 8'h04, 1'b0, 1'b0, {8'h07, 1'b0, 1'b0});
        @(negedge clk);

        // Directed vectors across every CHUNK size.
        for (int v = 0; v < 14; v++) begin
            for (int m = 1; m < 5; m++) begin
                run_op(m, vt[v].a, vt[v].b, vt[v].c, vt[v].s, {vt[v].r, vt[v].co, vt[v].ov});
            end
        end

        // Full-adder truth table on the 1-bit instance.
        for (int t = 0; t < 8; t++) begin
            run_op(0, {7'b0, 1'(t >> 2)}, {7'b0, 1'(t >> 1)}, 1'(t), 1'b0,
                   {7'b0, sum_tt[t], cout_tt[t], ovf_tt[t]});
        end

        repeat (4) @(negedge clk);
        for (int m = 0; m < 5; m++) begin
            check("pending_results", m, 32'(exp_q[m].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
